// File: rtl/core_pkg.sv
// Shared definitions for the core data-side request router.
// Holds the uncached FSM state encoding, bus widths, parameter defaults
// and the captured uncached request payload.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;

  // Defaults for the router parameters
  localparam int unsigned    TIMEOUT_W_DEF   = 8;
  localparam logic [XLEN-1:0] NC_ERR_DATA_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_NC_REQ  = 2'd1,
    ST_NC_WAIT = 2'd2
  } nc_state_e;

  // Uncached request captured at acceptance
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic            we;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } nc_req_t;

endpackage

// File: rtl/core_nc_timer.sv
// Response watchdog for uncached transactions.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   clr        restart the count at zero
//   en         count this cycle (saturates at all-ones)
//   expired_c  high during the enabled cycle in which the count reaches
//              all-ones, i.e. the last cycle a response is still accepted
module core_nc_timer #(
  parameter int unsigned W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam logic [W-1:0] CNT_MAX  = '1;
  localparam logic [W-1:0] CNT_LAST = CNT_MAX - W'(1);

  logic [W-1:0] count;

  // Saturating up-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != CNT_MAX)) begin
      count <= count + W'(1);
    end
  end

  assign expired_c = en & (count == CNT_LAST);

endmodule

// File: rtl/core_ncache_router.sv
// Data-side request router placed after the core CSR block.
// Each LSU request is classified against ncache_base/ncache_mask at
// acceptance: cacheable requests pass combinationally to the D-cache,
// non-cacheable ones are captured and issued on the uncached bus under a
// small FSM with a response watchdog. Only one transaction is ever
// outstanding.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ncache_base/mask         non-cacheable region from CSRs
//   lsu_req_*                LSU request (val/ack handshake)
//   lsu_resp_*               one response pulse per request (err = timeout)
//   dc_req_*, dc_resp_*      D-cache request / response
//   nc_req_*, nc_resp_*      uncached bus request / response
module core_ncache_router
  import core_pkg::*;
#(
  parameter int unsigned     TIMEOUT_W   = TIMEOUT_W_DEF,
  parameter logic [XLEN-1:0] NC_ERR_DATA = NC_ERR_DATA_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] ncache_base,
  input  logic [XLEN-1:0] ncache_mask,
  input  logic            lsu_req_val,
  output logic            lsu_req_ack,
  input  logic [XLEN-1:0] lsu_req_addr,
  input  logic            lsu_req_we,
  input  logic [BE_W-1:0] lsu_req_be,
  input  logic [XLEN-1:0] lsu_req_wdata,
  output logic            lsu_resp_val,
  output logic [XLEN-1:0] lsu_resp_data,
  output logic            lsu_resp_err,
  output logic            dc_req_val,
  input  logic            dc_req_ack,
  output logic [XLEN-1:0] dc_req_addr,
  output logic            dc_req_we,
  output logic [BE_W-1:0] dc_req_be,
  output logic [XLEN-1:0] dc_req_wdata,
  input  logic            dc_resp_val,
  input  logic [XLEN-1:0] dc_resp_data,
  output logic            nc_req_val,
  input  logic            nc_req_ack,
  output logic [XLEN-1:0] nc_req_addr,
  output logic            nc_req_we,
  output logic [BE_W-1:0] nc_req_be,
  output logic [XLEN-1:0] nc_req_wdata,
  input  logic            nc_resp_val,
  input  logic [XLEN-1:0] nc_resp_data
);

  nc_state_e       state;
  nc_req_t         nc_q;
  logic            dc_busy;
  logic            resp_val_q;
  logic            resp_err_q;
  logic [XLEN-1:0] resp_data_q;

  logic hit_nc_c;
  logic free_c;
  logic nc_accept_c;
  logic dc_fire_c;
  logic tmr_en_c;
  logic tmr_expired_c;

  // Region match and acceptance window (nothing accepted while in reset)
  assign hit_nc_c    = ((lsu_req_addr & ncache_mask) == (ncache_base & ncache_mask));
  assign free_c      = (state == ST_IDLE) & ~dc_busy & ~rst;
  assign nc_accept_c = lsu_req_val & hit_nc_c & free_c;
  assign dc_fire_c   = dc_req_val & dc_req_ack;

  // Cacheable path is a straight pass-through
  assign dc_req_val   = lsu_req_val & ~hit_nc_c & free_c;
  assign dc_req_addr  = lsu_req_addr;
  assign dc_req_we    = lsu_req_we;
  assign dc_req_be    = lsu_req_be;
  assign dc_req_wdata = lsu_req_wdata;

  assign lsu_req_ack = nc_accept_c | dc_fire_c;

  // Uncached request is driven from the captured copy
  assign nc_req_val   = (state == ST_NC_REQ);
  assign nc_req_addr  = nc_q.addr;
  assign nc_req_we    = nc_q.we;
  assign nc_req_be    = nc_q.be;
  assign nc_req_wdata = nc_q.wdata;

  // Registered uncached response and same-cycle D-cache response never
  // coincide: the former only appears in IDLE with dc_busy clear.
  assign lsu_resp_val  = resp_val_q | (dc_busy & dc_resp_val);
  assign lsu_resp_data = resp_val_q ? resp_data_q :
                         ((dc_busy & dc_resp_val) ? dc_resp_data : '0);
  assign lsu_resp_err  = resp_val_q & resp_err_q;

  assign tmr_en_c = (state != ST_IDLE);

  core_nc_timer #(
    .W (TIMEOUT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (nc_accept_c),
    .en        (tmr_en_c),
    .expired_c (tmr_expired_c)
  );

  // Uncached FSM, D-cache busy tracking and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      nc_q        <= '0;
      dc_busy     <= 1'b0;
      resp_val_q  <= 1'b0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      resp_val_q <= 1'b0;

      if (dc_fire_c) begin
        dc_busy <= 1'b1;
      end else if (dc_resp_val) begin
        dc_busy <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (nc_accept_c) begin
            nc_q  <= '{addr: lsu_req_addr, we: lsu_req_we,
                       be: lsu_req_be, wdata: lsu_req_wdata};
            state <= ST_NC_REQ;
          end
        end
        ST_NC_REQ: begin
          if (tmr_expired_c) begin
            resp_val_q  <= 1'b1;
            resp_err_q  <= 1'b1;
            resp_data_q <= NC_ERR_DATA;
            state       <= ST_IDLE;
          end else if (nc_req_ack) begin
            state <= ST_NC_WAIT;
          end
        end
        ST_NC_WAIT: begin
          // A response in the final watchdog cycle still counts
          if (nc_resp_val) begin
            resp_val_q  <= 1'b1;
            resp_err_q  <= 1'b0;
            resp_data_q <= nc_q.we ? '0 : nc_resp_data;
            state       <= ST_IDLE;
          end else if (tmr_expired_c) begin
            resp_val_q  <= 1'b1;
            resp_err_q  <= 1'b1;
            resp_data_q <= NC_ERR_DATA;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_ncache_router.sv
// Testbench for core_ncache_router: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (at most one outstanding request, uncached
// requests age out 2^TW-1 cycles after acceptance).
module tb_core_ncache_router;

  localparam int unsigned TW     = 4;
  localparam int          TO_CYC = (1 << TW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ncache_base = 32'h8000_0000;
  logic [31:0] ncache_mask = 32'hF000_0000;
  logic        lsu_req_val = 1'b0;
  logic        lsu_req_ack;
  logic [31:0] lsu_req_addr = '0;
  logic        lsu_req_we = 1'b0;
  logic [3:0]  lsu_req_be = '0;
  logic [31:0] lsu_req_wdata = '0;
  logic        lsu_resp_val;
  logic [31:0] lsu_resp_data;
  logic        lsu_resp_err;
  logic        dc_req_val;
  logic        dc_req_ack = 1'b0;
  logic [31:0] dc_req_addr;
  logic        dc_req_we;
  logic [3:0]  dc_req_be;
  logic [31:0] dc_req_wdata;
  logic        dc_resp_val = 1'b0;
  logic [31:0] dc_resp_data = '0;
  logic        nc_req_val;
  logic        nc_req_ack = 1'b0;
  logic [31:0] nc_req_addr;
  logic        nc_req_we;
  logic [3:0]  nc_req_be;
  logic [31:0] nc_req_wdata;
  logic        nc_resp_val = 1'b0;
  logic [31:0] nc_resp_data = '0;

  int n_chk  = 0;
  int n_pass = 0;

  core_ncache_router #(.TIMEOUT_W(TW), .NC_ERR_DATA(32'h0)) dut (
    .clk(clk), .rst(rst),
    .ncache_base(ncache_base), .ncache_mask(ncache_mask),
    .lsu_req_val(lsu_req_val), .lsu_req_ack(lsu_req_ack),
    .lsu_req_addr(lsu_req_addr), .lsu_req_we(lsu_req_we),
    .lsu_req_be(lsu_req_be), .lsu_req_wdata(lsu_req_wdata),
    .lsu_resp_val(lsu_resp_val), .lsu_resp_data(lsu_resp_data),
    .lsu_resp_err(lsu_resp_err),
    .dc_req_val(dc_req_val), .dc_req_ack(dc_req_ack),
    .dc_req_addr(dc_req_addr), .dc_req_we(dc_req_we),
    .dc_req_be(dc_req_be), .dc_req_wdata(dc_req_wdata),
    .dc_resp_val(dc_resp_val), .dc_resp_data(dc_resp_data),
    .nc_req_val(nc_req_val), .nc_req_ack(nc_req_ack),
    .nc_req_addr(nc_req_addr), .nc_req_we(nc_req_we),
    .nc_req_be(nc_req_be), .nc_req_wdata(nc_req_wdata),
    .nc_resp_val(nc_resp_val), .nc_resp_data(nc_resp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  // kind: 0 = nothing outstanding, 1 = D-cache request, 2 = uncached request
  int          kind = 0;
  int          cyc = 0;
  int          m_acc = 0;
  bit          m_issued = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_be = '0;
  bit          p_val = 1'b0;
  bit          p_err = 1'b0;
  logic [31:0] p_data = '0;

  always @(negedge clk) begin : model_blk
    bit          hit, free, e_ack, e_dcv, e_ncv, e_rv, e_re;
    logic [31:0] e_rd;
    int          k0;
    hit   = ((lsu_req_addr & ncache_mask) == (ncache_base & ncache_mask));
    free  = (kind == 0) && !rst;
    e_dcv = lsu_req_val && !hit && free;
    e_ack = free && lsu_req_val && (hit || dc_req_ack);
    e_ncv = (kind == 2) && !m_issued;
    e_rv = 1'b0; e_re = 1'b0; e_rd = '0;
    if (p_val) begin
      e_rv = 1'b1; e_re = p_err; e_rd = p_data;
    end else if (kind == 1 && dc_resp_val) begin
      e_rv = 1'b1; e_re = 1'b0; e_rd = dc_resp_data;
    end

    chk("m_lsu_req_ack", 32'(lsu_req_ack), 32'(e_ack));
    chk("m_dc_req_val", 32'(dc_req_val), 32'(e_dcv));
    chk("m_nc_req_val", 32'(nc_req_val), 32'(e_ncv));
    chk("m_lsu_resp_val", 32'(lsu_resp_val), 32'(e_rv));
    if (e_rv) begin
      chk("m_lsu_resp_data", lsu_resp_data, e_rd);
      chk("m_lsu_resp_err", 32'(lsu_resp_err), 32'(e_re));
    end
    if (e_dcv) chk("m_dc_req_addr", dc_req_addr, lsu_req_addr);
    if (e_ncv) begin
      chk("m_nc_req_addr", nc_req_addr, m_addr);
      chk("m_nc_req_wdata", nc_req_wdata, m_wdata);
      chk("m_nc_req_we_be", {27'h0, nc_req_we, nc_req_be}, {27'h0, m_we, m_be});
    end

    // advance to the next cycle
    p_val = 1'b0;
    k0 = kind;
    if (rst) begin
      kind = 0;
    end else begin
      if (k0 == 1 && dc_resp_val) begin
        kind = 0;
      end else if (k0 == 2) begin
        if (m_issued && nc_resp_val) begin
          p_val = 1'b1; p_err = 1'b0; p_data = m_we ? 32'h0 : nc_resp_data; kind = 0;
        end else if (cyc - m_acc == TO_CYC) begin
          p_val = 1'b1; p_err = 1'b1; p_data = 32'h0; kind = 0;
        end else if (!m_issued && nc_req_ack) begin
          m_issued = 1'b1;
        end
      end
      if (free && lsu_req_val) begin
        if (hit) begin
          kind = 2; m_acc = cyc; m_issued = 1'b0;
          m_addr = lsu_req_addr; m_we = lsu_req_we; m_be = lsu_req_be; m_wdata = lsu_req_wdata;
        end else if (dc_req_ack) begin
          kind = 1;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_in();
    lsu_req_val = 1'b0; dc_req_ack = 1'b0; dc_resp_val = 1'b0;
    nc_req_ack = 1'b0; nc_resp_val = 1'b0;
  endtask

  task automatic req(input logic [31:0] a, input logic we, input logic [31:0] wd);
    lsu_req_val = 1'b1; lsu_req_addr = a; lsu_req_we = we;
    lsu_req_be = 4'hF; lsu_req_wdata = wd;
  endtask

  initial begin
    int slow;
    logic [31:0] mopt [4];
    mopt[0] = 32'hF000_0000; mopt[1] = 32'hFFFF_F000;
    mopt[2] = 32'h0000_0000; mopt[3] = 32'hFFFF_FFFF;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // reset state
    tick(); idle_in(); settle();
    chk("rst_lsu_resp_val", 32'(lsu_resp_val), 32'h0);
    chk("rst_nc_req_val", 32'(nc_req_val), 32'h0);
    chk("rst_dc_req_val", 32'(dc_req_val), 32'h0);
    chk("rst_lsu_req_ack", 32'(lsu_req_ack), 32'h0);

    // 1: cacheable read
    tick(); idle_in(); req(32'h0000_1000, 1'b0, 32'h0); dc_req_ack = 1'b1; settle();
    chk("t1_dc_req_val", 32'(dc_req_val), 32'h1);
    chk("t1_nc_req_val", 32'(nc_req_val), 32'h0);
    chk("t1_ack", 32'(lsu_req_ack), 32'h1);
    tick(); idle_in(); dc_resp_val = 1'b1; dc_resp_data = 32'h0000_1234; settle();
    chk("t1_resp_val", 32'(lsu_resp_val), 32'h1);
    chk("t1_resp_data", lsu_resp_data, 32'h0000_1234);
    chk("t1_resp_err", 32'(lsu_resp_err), 32'h0);

    // 2: uncached read, ack at +2, response at +3
    tick(); idle_in(); req(32'h8000_0010, 1'b0, 32'h0); settle();
    chk("t2_ack", 32'(lsu_req_ack), 32'h1);
    chk("t2_dc_req_val", 32'(dc_req_val), 32'h0);
    tick(); idle_in(); settle();
    chk("t2_nc_req_val", 32'(nc_req_val), 32'h1);
    chk("t2_nc_req_addr", nc_req_addr, 32'h8000_0010);
    tick(); idle_in(); nc_req_ack = 1'b1; settle();
    tick(); idle_in(); nc_resp_val = 1'b1; nc_resp_data = 32'hCAFE_0001; settle();
    chk("t2_resp_not_yet", 32'(lsu_resp_val), 32'h0);
    tick(); idle_in(); settle();
    chk("t2_resp_val", 32'(lsu_resp_val), 32'h1);
    chk("t2_resp_data", lsu_resp_data, 32'hCAFE_0001);
    chk("t2_resp_err", 32'(lsu_resp_err), 32'h0);
    tick(); idle_in(); settle();
    chk("t2_resp_pulse", 32'(lsu_resp_val), 32'h0);

    // 3: watchdog timeout, then late response dropped
    tick(); idle_in(); req(32'h8000_0020, 1'b0, 32'h0); settle();
    chk("t3_ack", 32'(lsu_req_ack), 32'h1);
    for (int c = 1; c <= 15; c++) begin
      tick(); idle_in(); if (c == 2) nc_req_ack = 1'b1; settle();
      chk("t3_no_resp", 32'(lsu_resp_val), 32'h0);
    end
    tick(); idle_in(); settle();
    chk("t3_to_val", 32'(lsu_resp_val), 32'h1);
    chk("t3_to_err", 32'(lsu_resp_err), 32'h1);
    chk("t3_to_data", lsu_resp_data, 32'h0);
    for (int c = 17; c <= 20; c++) begin
      tick(); idle_in();
      if (c == 20) begin nc_resp_val = 1'b1; nc_resp_data = 32'h1111_1111; end
      settle();
      chk("t3_quiet", 32'(lsu_resp_val), 32'h0);
    end
    tick(); idle_in(); settle();
    chk("t3_late_drop", 32'(lsu_resp_val), 32'h0);

    // 4: uncached write then held cacheable read
    tick(); idle_in(); req(32'h8000_0100, 1'b1, 32'h0000_55AA); settle();
    chk("t4_w_ack", 32'(lsu_req_ack), 32'h1);
    tick(); idle_in(); req(32'h0000_2000, 1'b0, 32'h0); dc_req_ack = 1'b1; nc_req_ack = 1'b1; settle();
    chk("t4_nc_wdata", nc_req_wdata, 32'h0000_55AA);
    chk("t4_r_blocked", 32'(lsu_req_ack), 32'h0);
    tick(); idle_in(); req(32'h0000_2000, 1'b0, 32'h0); dc_req_ack = 1'b1;
    nc_resp_val = 1'b1; nc_resp_data = 32'h0000_0777; settle();
    chk("t4_r_wait", 32'(lsu_req_ack), 32'h0);
    tick(); idle_in(); req(32'h0000_2000, 1'b0, 32'h0); dc_req_ack = 1'b1; settle();
    chk("t4_w_resp", 32'(lsu_resp_val), 32'h1);
    chk("t4_w_data0", lsu_resp_data, 32'h0);
    chk("t4_r_ack", 32'(lsu_req_ack), 32'h1);
    chk("t4_r_dc_val", 32'(dc_req_val), 32'h1);
    tick(); idle_in(); dc_resp_val = 1'b1; dc_resp_data = 32'h0000_0042; settle();
    chk("t4_r_data", lsu_resp_data, 32'h0000_0042);

    // 5: reset in NC_WAIT abandons the transaction
    tick(); idle_in(); req(32'h8000_0030, 1'b0, 32'h0); settle();
    tick(); idle_in(); nc_req_ack = 1'b1; settle();
    tick(); idle_in(); rst = 1'b1; settle();
    tick(); idle_in(); rst = 1'b0; nc_resp_val = 1'b1; nc_resp_data = 32'h0BAD_0BAD; settle();
    chk("t5_nc_req_val", 32'(nc_req_val), 32'h0);
    chk("t5_resp_val", 32'(lsu_resp_val), 32'h0);
    tick(); idle_in(); req(32'h0000_3000, 1'b0, 32'h0); dc_req_ack = 1'b1; settle();
    chk("t5_dropped", 32'(lsu_resp_val), 32'h0);
    chk("t5_idle_ack", 32'(lsu_req_ack), 32'h1);
    tick(); idle_in(); dc_resp_val = 1'b1; dc_resp_data = 32'h9; settle();
    chk("t5_dc_data", lsu_resp_data, 32'h9);

    // 6: mask extremes
    tick(); idle_in(); ncache_base = 32'h8000_0000; ncache_mask = 32'h0;
    req(32'h0000_0040, 1'b0, 32'h0); settle();
    chk("t6_m0_ack", 32'(lsu_req_ack), 32'h1);
    chk("t6_m0_dc", 32'(dc_req_val), 32'h0);
    tick(); idle_in(); nc_req_ack = 1'b1; settle();
    chk("t6_m0_nc_addr", nc_req_addr, 32'h0000_0040);
    tick(); idle_in(); nc_resp_val = 1'b1; nc_resp_data = 32'hA5; settle();
    tick(); idle_in(); settle();
    chk("t6_m0_resp", lsu_resp_data, 32'hA5);
    tick(); idle_in(); ncache_base = 32'h0; ncache_mask = 32'hFFFF_FFFF;
    req(32'h0000_0004, 1'b0, 32'h0); dc_req_ack = 1'b1; settle();
    chk("t6_m1_dc", 32'(dc_req_val), 32'h1);
    tick(); idle_in(); dc_resp_val = 1'b1; settle();
    tick(); idle_in(); req(32'h0000_0000, 1'b0, 32'h0); dc_req_ack = 1'b1; settle();
    chk("t6_m1_zero_dc", 32'(dc_req_val), 32'h0);
    chk("t6_m1_zero_ack", 32'(lsu_req_ack), 32'h1);
    tick(); idle_in(); nc_req_ack = 1'b1; settle();
    tick(); idle_in(); nc_resp_val = 1'b1; nc_resp_data = 32'h5A; settle();
    tick(); idle_in(); settle();
    chk("t6_m1_resp", lsu_resp_data, 32'h5A);

    // randomized traffic, checked by the model every cycle
    ncache_base = 32'h8000_0000; ncache_mask = 32'hF000_0000;
    for (int i = 0; i < 4000; i++) begin
      tick();
      slow = (i / 250) % 2;
      if ($urandom_range(0, 99) == 0) begin
        ncache_mask = mopt[$urandom_range(0, 3)];
        ncache_base = $urandom;
      end
      rst = ($urandom_range(0, 299) == 0);
      lsu_req_val   = !rst && ($urandom_range(0, 2) != 0);
      lsu_req_addr  = $urandom_range(0, 1) ? ((ncache_base & ncache_mask) | ($urandom & ~ncache_mask))
                                           : $urandom;
      lsu_req_we    = 1'($urandom_range(0, 1));
      lsu_req_be    = 4'($urandom);
      lsu_req_wdata = $urandom;
      dc_req_ack    = 1'($urandom_range(0, 1));
      dc_resp_val   = ($urandom_range(0, 3) == 0);
      dc_resp_data  = $urandom;
      nc_req_ack    = ($urandom_range(0, 2) == 0);
      nc_resp_val   = slow ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 3) == 0);
      nc_resp_data  = $urandom;
    end
    tick(); idle_in(); rst = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
